issue_queue: RTL and testbench
==============================

ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter IQ_DEPTH, default 8, number of entries (power of two, >= 2*DISPATCH_WIDTH).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port flush_i  input  1  synchronous pipeline flush.
REQ-005 SHALL have port dispatch_valid_i  input  DISPATCH_WIDTH  per-lane entry valid from the dispatch queue, lanes contiguous from lane 0.
REQ-006 SHALL have port dispatch_data_i  input  DISPATCH_WIDTH x DqEntrySt  entries (fields include src0, src1, src0_ready, src1_ready, pdest).
REQ-007 SHALL have port dispatch_ready_o  output  DISPATCH_WIDTH  per-lane accept; all bits equal.
REQ-008 SHALL have port issue_valid_o  output  1  selected entry valid.
REQ-009 SHALL have port issue_data_o  output  DqEntrySt  selected entry.
REQ-010 SHALL have port issue_ready_i  input  1  execution side accepts.
REQ-011 SHALL have ports wb_i  input  WB_WIDTH  and wb_pdest_i  input  WB_WIDTH x clog2(PHY_REG_NUM)  writeback wakeup tags.

Function
REQ-012 SHALL hold entries in a collapsing array, slot 0 oldest; occupied slots always contiguous 0..cnt-1.
REQ-013 SHALL drive dispatch_ready_o all-ones iff registered cnt <= IQ_DEPTH - DISPATCH_WIDTH; acceptance depends on registered state only.
REQ-014 SHALL, on a lane handshake (valid & ready), append accepted entries in lane order after the surviving entries of the same cycle.
REQ-015 SHALL mark an entry eligible when src0_ready and src1_ready are both set.
REQ-016 SHALL select the lowest-index eligible entry; issue_valid_o = any eligible; issue_data_o = that entry.
REQ-017 SHALL remove the selected entry only when issue_valid_o & issue_ready_i, shifting all higher entries down one slot in the same cycle.
REQ-018 SHALL, for every valid wb_i[j], set srcN_ready in every stored entry whose srcN equals wb_pdest_i[j], effective from the next cycle.
REQ-019 SHALL apply the same wakeup to entries being written this cycle, so a wakeup coincident with dispatch is never lost.
REQ-020 SHALL update cnt as cnt + accepted - issued, never exceeding IQ_DEPTH nor going below 0.
REQ-021 SHALL, when empty, drive issue_valid_o = 0 irrespective of dispatch inputs (no dispatch-to-issue bypass).
REQ-022 SHALL, when issue_ready_i is low, hold issue_data_o stable unless an older entry becomes eligible.
REQ-023 SHALL, on flush_i, clear all valid state and cnt at the next edge, ignoring that cycle's dispatch, issue and wakeup.

Reset
REQ-024 SHALL, while rst_n = 0, force cnt = 0, all entries cleared, issue_valid_o = 0, dispatch_ready_o all-ones.
REQ-025 SHALL abandon any in-flight issue handshake when reset asserts mid-operation; no entry survives.

Configuration
REQ-026 SHALL, with IQ_FAST_WAKEUP_EN defined, compute eligibility from post-wakeup ready bits, so an entry whose last operand is woken in cycle N may issue in cycle N.
REQ-027 SHALL, without IQ_FAST_WAKEUP_EN, compute eligibility from registered ready bits only, so that entry first issues in cycle N+1.

Structure
REQ-028 SHALL take DqEntrySt, DISPATCH_WIDTH, WB_WIDTH, PHY_REG_NUM from the shared Scheduler/config headers; no new typedefs are local.
REQ-029 SHALL implement oldest-ready selection as sub-module iq_age_select (request vector in, one-hot grant and index out).

Verification
REQ-030 SHALL cover: reset, then 2 entries dispatched with all srcs ready -> issue slot 0 next cycle, slot 1 the cycle after, cnt returns to 0.
REQ-031 SHALL cover: entry A src0=5 not ready, entry B ready -> B issues first; wb_i=1, wb_pdest_i=5 -> A issues in same cycle (EN) or next cycle (no EN).
REQ-032 SHALL cover: fill to IQ_DEPTH-DISPATCH_WIDTH+1 with issue_ready_i=0 -> dispatch_ready_o=0; one issue -> ready reasserts next cycle.
REQ-033 SHALL cover: wb for pdest 9 in the same cycle as dispatch of entry with src1=9 not ready -> entry stored with src1_ready=1.
REQ-034 SHALL cover: simultaneous dispatch of 2, issue of 1 from the middle slot and flush_i=1 -> next cycle cnt=0, issue_valid_o=0.
REQ-035 SHALL cover: rst_n dropped mid-stream with issue_ready_i=1 -> outputs reach reset values immediately, without a clock edge.

Source files
------------

// File: rtl/issue_queue_pkg.sv
// Shared scheduler types and widths for the issue queue, plus the operand wakeup helper.
package issue_queue_pkg;

    localparam int unsigned DISPATCH_WIDTH = 2;
    localparam int unsigned WB_WIDTH       = 2;
    localparam int unsigned PHY_REG_NUM    = 64;
    localparam int unsigned PREG_W         = $clog2(PHY_REG_NUM);
    localparam int unsigned TAG_W          = 8;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [PREG_W-1:0] pdest;
        logic [PREG_W-1:0] src0;
        logic [PREG_W-1:0] src1;
        logic              src0_ready;
        logic              src1_ready;
    } DqEntrySt;

    // Sets the ready bit of any source operand matching a valid writeback tag.
    function automatic DqEntrySt iq_wakeup(
        input DqEntrySt                         e,
        input logic [WB_WIDTH-1:0]              wb,
        input logic [WB_WIDTH-1:0][PREG_W-1:0]  wb_pdest
    );
        DqEntrySt r;
        r = e;
        for (int j = 0; j < WB_WIDTH; j++) begin
            if (wb[j]) begin
                if (e.src0 == wb_pdest[j]) r.src0_ready = 1'b1;
                if (e.src1 == wb_pdest[j]) r.src1_ready = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/issue_queue_age_select.sv
// Oldest-ready picker: lowest-index request wins; one-hot grant, index and any-request out.
module iq_age_select #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    output logic [N-1:0]     o_grant_c,
    output logic [IDX_W-1:0] o_idx_c,
    output logic             o_any_c
);

    // Descending scan so the last hit written is the lowest index.
    always_comb begin
        o_grant_c = '0;
        o_idx_c   = '0;
        o_any_c   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_grant_c    = '0;
                o_grant_c[i] = 1'b1;
                o_idx_c      = IDX_W'(i);
                o_any_c      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_queue.sv
// Collapsing in-order-age issue queue with writeback wakeup and oldest-ready issue.
// Define IQ_FAST_WAKEUP_EN to let an operand woken this cycle make its entry issuable this cycle.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int unsigned IQ_DEPTH = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush_i,
    input  logic [DISPATCH_WIDTH-1:0]           dispatch_valid_i,
    input  DqEntrySt [DISPATCH_WIDTH-1:0]       dispatch_data_i,
    output logic [DISPATCH_WIDTH-1:0]           dispatch_ready_o,
    output logic                                issue_valid_o,
    output DqEntrySt                            issue_data_o,
    input  logic                                issue_ready_i,
    input  logic [WB_WIDTH-1:0]                 wb_i,
    input  logic [WB_WIDTH-1:0][PREG_W-1:0]     wb_pdest_i
);

    localparam int unsigned CNT_W    = $clog2(IQ_DEPTH + 1);
    localparam int unsigned IDX_W    = $clog2(IQ_DEPTH);
    localparam int unsigned FREE_LIM = IQ_DEPTH - DISPATCH_WIDTH;

    DqEntrySt           r_entries [IQ_DEPTH];
    logic [CNT_W-1:0]   r_cnt;

    DqEntrySt           w_woken   [IQ_DEPTH];
    DqEntrySt           w_view    [IQ_DEPTH];
    DqEntrySt           w_next    [IQ_DEPTH];
    logic [IQ_DEPTH-1:0] w_req;
    logic [IQ_DEPTH-1:0] w_grant;
    logic [IQ_DEPTH-1:0] w_shift;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_any;
    logic               w_fire;
    logic               w_accept;
    logic               w_seen;
    logic [CNT_W-1:0]   w_pos;

    // Acceptance looks only at the registered count so it never depends on same-cycle issue.
    assign w_accept         = (r_cnt <= CNT_W'(FREE_LIM));
    assign dispatch_ready_o = {DISPATCH_WIDTH{w_accept}};

    always_comb begin
        for (int i = 0; i < IQ_DEPTH; i++) begin
            w_woken[i] = iq_wakeup(r_entries[i], wb_i, wb_pdest_i);
        end
    end

`ifdef IQ_FAST_WAKEUP_EN
    assign w_view = w_woken;
`else
    assign w_view = r_entries;
`endif

    always_comb begin
        for (int i = 0; i < IQ_DEPTH; i++) begin
            w_req[i] = (CNT_W'(i) < r_cnt) && w_view[i].src0_ready && w_view[i].src1_ready;
        end
    end

    iq_age_select #(
        .N     (IQ_DEPTH),
        .IDX_W (IDX_W)
    ) u_age_select (
        .i_req     (w_req),
        .o_grant_c (w_grant),
        .o_idx_c   (w_sel_idx),
        .o_any_c   (w_any)
    );

    assign issue_valid_o = w_any;
    assign issue_data_o  = w_view[w_sel_idx];
    assign w_fire        = w_any & issue_ready_i;

    // Collapse above the issued slot, then append accepted lanes after the survivors.
    always_comb begin
        w_seen = 1'b0;
        for (int i = 0; i < IQ_DEPTH; i++) begin
            w_seen     = w_seen | w_grant[i];
            w_shift[i] = w_fire & w_seen;
        end
        for (int i = 0; i < IQ_DEPTH - 1; i++) begin
            w_next[i] = w_shift[i] ? w_woken[i + 1] : w_woken[i];
        end
        w_next[IQ_DEPTH-1] = w_shift[IQ_DEPTH-1] ? '0 : w_woken[IQ_DEPTH-1];
        w_pos = r_cnt - CNT_W'(w_fire);
        if (w_accept) begin
            for (int k = 0; k < DISPATCH_WIDTH; k++) begin
                if (dispatch_valid_i[k]) begin
                    w_next[IDX_W'(w_pos)] = iq_wakeup(dispatch_data_i[k], wb_i, wb_pdest_i);
                    w_pos                 = w_pos + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            for (int i = 0; i < IQ_DEPTH; i++) r_entries[i] <= '0;
        end else if (flush_i) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_pos;
            for (int i = 0; i < IQ_DEPTH; i++) r_entries[i] <= w_next[i];
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: stimulus pushes expected issues, a monitor pops and compares.
module tb_issue_queue;
    import issue_queue_pkg::*;

    logic                              clk;
    logic                              rst_n;
    logic                              flush;
    logic [DISPATCH_WIDTH-1:0]         dv;
    DqEntrySt [DISPATCH_WIDTH-1:0]     dd;
    logic [DISPATCH_WIDTH-1:0]         dispatch_ready_o;
    logic                              issue_valid_o;
    DqEntrySt                          issue_data_o;
    logic                              ir;
    logic [WB_WIDTH-1:0]               wb;
    logic [WB_WIDTH-1:0][PREG_W-1:0]   wbp;

    int total = 0;
    int bad   = 0;
    DqEntrySt exp_q[$];
    DqEntrySt tmp;

    issue_queue #(.IQ_DEPTH(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush_i          (flush),
        .dispatch_valid_i (dv),
        .dispatch_data_i  (dd),
        .dispatch_ready_o (dispatch_ready_o),
        .issue_valid_o    (issue_valid_o),
        .issue_data_o     (issue_data_o),
        .issue_ready_i    (ir),
        .wb_i             (wb),
        .wb_pdest_i       (wbp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef IQ_FAST_WAKEUP_EN
    localparam int FAST = 1;
`else
    localparam int FAST = 0;
`endif

    function automatic DqEntrySt mk(input int tag, input int s0, input int r0,
                                    input int s1, input int r1, input int pd);
        DqEntrySt e;
        e.tag        = TAG_W'(tag);
        e.pdest      = PREG_W'(pd);
        e.src0       = PREG_W'(s0);
        e.src1       = PREG_W'(s1);
        e.src0_ready = r0 != 0;
        e.src1_ready = r1 != 0;
        return e;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every presented handshake must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && issue_valid_o && ir) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL issue_unexpected: got tag=%0d data=%h expected none", issue_data_o.tag, issue_data_o);
            end else begin
                tmp = exp_q.pop_front();
                if (issue_data_o !== tmp) begin
                    bad++;
                    $display("FAIL issue_data: got tag=%0d data=%h expected tag=%0d data=%h",
                             issue_data_o.tag, issue_data_o, tmp.tag, tmp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        DqEntrySt a;
        rst_n = 1'b0; flush = 1'b0; dv = '0; dd = '0; ir = 1'b0; wb = '0; wbp = '0;
        #2;
        chk("rst_ivalid", int'(issue_valid_o), 0);
        chk("rst_dready", int'(dispatch_ready_o), 3);
        #20;
        tick();
        rst_n = 1'b1;

        // Two ready entries: slot 0 then slot 1, then empty; no bypass while empty.
        dd[0] = mk(1, 1, 1, 2, 1, 10);
        dd[1] = mk(2, 3, 1, 4, 1, 11);
        dv = 2'b11; ir = 1'b1;
        exp_q.push_back(dd[0]); exp_q.push_back(dd[1]);
        @(negedge clk); chk("empty_no_bypass", int'(issue_valid_o), 0);
        tick(); dv = '0;
        @(negedge clk); chk("t2_slot0_valid", int'(issue_valid_o), 1);
        tick();
        @(negedge clk); chk("t2_slot1_valid", int'(issue_valid_o), 1);
        tick();
        @(negedge clk); chk("t2_drained", int'(issue_valid_o), 0);
        chk("t2_dready", int'(dispatch_ready_o), 3);

        // A waits on p5, B ready: B first, A after wakeup.
        tick(); ir = 1'b0;
        dd[0] = mk(3, 5, 0, 6, 1, 12);
        dd[1] = mk(4, 7, 1, 8, 1, 13);
        dv = 2'b11;
        a = dd[0]; a.src0_ready = 1'b1;
        exp_q.push_back(dd[1]); exp_q.push_back(a);
        tick(); dv = '0; ir = 1'b1;
        @(negedge clk); chk("t3_b_first", int'(issue_valid_o), 1);
        tick(); wb = 2'b01; wbp[0] = PREG_W'(5);
        @(negedge clk); chk("t3_wake_cycle", int'(issue_valid_o), FAST);
        tick(); wb = '0;
        @(negedge clk); chk("t3_after_wake", int'(issue_valid_o), 1 - FAST);
        tick();
        @(negedge clk); chk("t3_empty", int'(issue_valid_o), 0);

        // Fill to DEPTH-DISPATCH_WIDTH+1 with issue blocked.
        tick(); ir = 1'b0;
        for (int c = 0; c < 3; c++) begin
            dd[0] = mk(10 + 2 * c, 1, 1, 2, 1, 20);
            dd[1] = mk(11 + 2 * c, 1, 1, 2, 1, 21);
            dv = 2'b11;
            exp_q.push_back(dd[0]); exp_q.push_back(dd[1]);
            @(negedge clk); chk("t4_fill_ready", int'(dispatch_ready_o), 3);
            tick();
        end
        dd[0] = mk(16, 1, 1, 2, 1, 22); dv = 2'b01;
        exp_q.push_back(dd[0]);
        @(negedge clk); chk("t4_boundary_ready", int'(dispatch_ready_o), 3);
        tick(); dv = '0;
        @(negedge clk); chk("t4_full_not_ready", int'(dispatch_ready_o), 0);
        dd[0] = mk(90, 1, 1, 2, 1, 23); dd[1] = mk(91, 1, 1, 2, 1, 24); dv = 2'b11;
        @(negedge clk); chk("t4_still_not_ready", int'(dispatch_ready_o), 0);
        tick(); dv = '0; ir = 1'b1;
        @(negedge clk); chk("t4_issue_one", int'(issue_valid_o), 1);
        tick(); ir = 1'b0;
        @(negedge clk); chk("t4_ready_reassert", int'(dispatch_ready_o), 3);
        tick(); ir = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            tick();
        end
        @(negedge clk); chk("t4_drained", int'(issue_valid_o), 0);

        // Wakeup coincident with dispatch is captured in the stored entry.
        tick(); ir = 1'b0;
        dd[0] = mk(20, 3, 1, 9, 0, 14); dv = 2'b01;
        wb = 2'b10; wbp[1] = PREG_W'(9);
        a = dd[0]; a.src1_ready = 1'b1;
        exp_q.push_back(a);
        tick(); dv = '0; wb = '0; ir = 1'b1;
        @(negedge clk); chk("t5_woken_on_write", int'(issue_valid_o), 1);
        tick();
        @(negedge clk); chk("t5_empty", int'(issue_valid_o), 0);

        // Flush with simultaneous dispatch and mid-slot issue.
        tick(); ir = 1'b0;
        dd[0] = mk(30, 7, 0, 8, 1, 15); dd[1] = mk(31, 1, 1, 2, 1, 16); dv = 2'b11;
        tick();
        dd[0] = mk(32, 1, 1, 2, 1, 17); dv = 2'b01;
        tick();
        dd[0] = mk(33, 1, 1, 2, 1, 18); dd[1] = mk(34, 1, 1, 2, 1, 19); dv = 2'b11;
        ir = 1'b1; flush = 1'b1;
        exp_q.push_back(mk(31, 1, 1, 2, 1, 16));
        @(negedge clk); chk("t6_mid_slot_valid", int'(issue_valid_o), 1);
        tick(); flush = 1'b0; dv = '0; wb = 2'b01; wbp[0] = PREG_W'(7);
        @(negedge clk); chk("t6_flush_ivalid", int'(issue_valid_o), 0);
        chk("t6_flush_dready", int'(dispatch_ready_o), 3);
        tick(); wb = '0;
        @(negedge clk); chk("t6_nothing_survives", int'(issue_valid_o), 0);

        // Asynchronous reset during an issue handshake.
        tick(); ir = 1'b0;
        dd[0] = mk(40, 1, 1, 2, 1, 25); dd[1] = mk(41, 1, 1, 2, 1, 26); dv = 2'b11;
        tick(); dv = '0; ir = 1'b1;
        exp_q.push_back(mk(40, 1, 1, 2, 1, 25));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_ivalid", int'(issue_valid_o), 0);
        chk("t7_rst_dready", int'(dispatch_ready_o), 3);
        tick(); tick();
        rst_n = 1'b1;
        @(negedge clk); chk("t7_after_rst_ivalid", int'(issue_valid_o), 0);
        chk("sb_all_issued", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
